// File: rtl/shifter_pipe.sv
// Pipelined multi-mode shifter with valid/ready flow control.
// Supports logical/arithmetic shifts and rotates, an over-range amount
// shortcut, a sticky flag for shifted-out bits and a pass-through tag.

package math_pkg;
  typedef enum logic [2:0] {
    SLL = 3'b000,
    SRL = 3'b100,
    SRA = 3'b101,
    SLB = 3'b011,
    SRB = 3'b111
  } shift_mode_e;
endpackage

module shifter_pipe
  import math_pkg::*;
#(
  parameter int Dw        = 8,
  parameter int NumStages = 1,
  parameter int TagW      = 1,
  localparam int Sw       = $clog2(Dw)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [Dw-1:0]   data_i,
  input  logic [Sw:0]     shamt_i,
  input  logic [2:0]      shift_mode_i,
  input  logic [TagW-1:0] tag_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [Dw-1:0]   data_o,
  output logic            sticky_o,
  output logic [TagW-1:0] tag_o
);

  // Internal operation kinds: every mode is reduced to one of these at entry.
  localparam logic [1:0] K_SHL = 2'd0;
  localparam logic [1:0] K_SHR = 2'd1;
  localparam logic [1:0] K_SRA = 2'd2;
  localparam logic [1:0] K_ROL = 2'd3;

  logic [Dw-1:0]        pre_data_s;
  logic [1:0]           pre_kind_s;
  logic [Sw-1:0]        pre_amt_s;
  logic                 pre_sticky_s;

  logic [Dw-1:0]        data_r   [NumStages];
  logic [1:0]           kind_r   [NumStages];
  logic [Sw-1:0]        amt_r    [NumStages];
  logic [TagW-1:0]      tag_r    [NumStages];
  logic                 sticky_r [NumStages];
  logic [NumStages-1:0] valid_r;

  logic [Dw-1:0]        src_data_s   [NumStages];
  logic [1:0]           src_kind_s   [NumStages];
  logic [Sw-1:0]        src_amt_s    [NumStages];
  logic [TagW-1:0]      src_tag_s    [NumStages];
  logic                 src_sticky_s [NumStages];
  logic [NumStages-1:0] src_valid_s;

  logic [Dw-1:0]        nxt_data_s   [NumStages];
  logic                 nxt_sticky_s [NumStages];
  logic [NumStages-1:0] rdy_s;

  // Decode the mode: over-range logical/arith shifts resolve here, SRB becomes a left rotate.
  always_comb begin
    pre_data_s   = data_i;
    pre_kind_s   = K_ROL;
    pre_amt_s    = '0;
    pre_sticky_s = 1'b0;
    case (shift_mode_i)
      SLL, SRL: begin
        pre_kind_s = (shift_mode_i == SLL) ? K_SHL : K_SHR;
        if (shamt_i[Sw]) begin
          pre_data_s   = '0;
          pre_sticky_s = |data_i;
        end else begin
          pre_amt_s = shamt_i[Sw-1:0];
        end
      end
      SRA: begin
        pre_kind_s = K_SRA;
        if (shamt_i[Sw]) begin
          pre_data_s   = {Dw{data_i[Dw-1]}};
          pre_sticky_s = |data_i;
        end else begin
          pre_amt_s = shamt_i[Sw-1:0];
        end
      end
      SLB: begin
        pre_amt_s = shamt_i[Sw-1:0];
      end
      SRB: begin
        pre_amt_s = -shamt_i[Sw-1:0];
      end
      default: begin
        pre_amt_s = '0;
      end
    endcase
  end

  // Present each stage with its upstream operand: the decoder for stage 0, else the previous slice.
  always_comb begin
    src_data_s[0]   = pre_data_s;
    src_kind_s[0]   = pre_kind_s;
    src_amt_s[0]    = pre_amt_s;
    src_tag_s[0]    = tag_i;
    src_sticky_s[0] = pre_sticky_s;
    src_valid_s[0]  = in_valid_i;
    for (int s = 1; s < NumStages; s++) begin
      src_data_s[s]   = data_r[s-1];
      src_kind_s[s]   = kind_r[s-1];
      src_amt_s[s]    = amt_r[s-1];
      src_tag_s[s]    = tag_r[s-1];
      src_sticky_s[s] = sticky_r[s-1];
      src_valid_s[s]  = valid_r[s-1];
    end
  end

  // Apply the mux levels owned by each stage, folding shifted-out bits into sticky.
  always_comb begin
    logic [Dw-1:0] d_s;
    logic          st_s;
    d_s  = '0;
    st_s = 1'b0;
    for (int s = 0; s < NumStages; s++) begin
      d_s  = src_data_s[s];
      st_s = src_sticky_s[s];
      for (int i = 0; i < Sw; i++) begin
        if ((((i * NumStages) / Sw) == s) && src_amt_s[s][i]) begin
          case (src_kind_s[s])
            K_SHL: begin
              st_s = st_s | (|(d_s & ~({Dw{1'b1}} >> (32'd1 << i))));
              d_s  = d_s << (32'd1 << i);
            end
            K_SHR: begin
              st_s = st_s | (|(d_s & ~({Dw{1'b1}} << (32'd1 << i))));
              d_s  = d_s >> (32'd1 << i);
            end
            K_SRA: begin
              st_s = st_s | (|(d_s & ~({Dw{1'b1}} << (32'd1 << i))));
              d_s  = $unsigned($signed(d_s) >>> (32'd1 << i));
            end
            default: begin
              d_s = (d_s << (32'd1 << i)) | (d_s >> (Dw - (32'd1 << i)));
            end
          endcase
        end else begin
          d_s = d_s;
        end
      end
      nxt_data_s[s]   = d_s;
      nxt_sticky_s[s] = st_s;
    end
  end

  // Ready ripples back from the consumer: a stage can take data if empty or draining.
  always_comb begin
    logic chain_s;
    chain_s = out_ready_i;
    for (int s = NumStages - 1; s >= 0; s--) begin
      chain_s  = !valid_r[s] || chain_s;
      rdy_s[s] = chain_s;
    end
  end

  // Pipeline slices: load on ready with valid upstream data, hold otherwise.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_r <= '0;
      for (int s = 0; s < NumStages; s++) begin
        data_r[s]   <= '0;
        kind_r[s]   <= K_SHL;
        amt_r[s]    <= '0;
        tag_r[s]    <= '0;
        sticky_r[s] <= 1'b0;
      end
    end else begin
      for (int s = 0; s < NumStages; s++) begin
        if (rdy_s[s]) begin
          valid_r[s] <= src_valid_s[s];
          if (src_valid_s[s]) begin
            data_r[s]   <= nxt_data_s[s];
            kind_r[s]   <= src_kind_s[s];
            amt_r[s]    <= src_amt_s[s];
            tag_r[s]    <= src_tag_s[s];
            sticky_r[s] <= nxt_sticky_s[s];
          end
        end
      end
    end
  end

  assign in_ready_o  = rdy_s[0];
  assign out_valid_o = valid_r[NumStages-1];
  assign data_o      = data_r[NumStages-1];
  assign sticky_o    = sticky_r[NumStages-1];
  assign tag_o       = tag_r[NumStages-1];

`ifndef MATH_CHECK_OFF
  shifter_pipe_chk #(.Dw(Dw), .NumStages(NumStages), .TagW(TagW)) u_chk (
    .clk       (clk_i),
    .rst_n     (rst_ni),
    .out_valid (out_valid_o),
    .out_ready (out_ready_i),
    .data      (data_o),
    .tag       (tag_o)
  );
`endif

endmodule

// Protocol and parameter checks for shifter_pipe.
module shifter_pipe_chk #(
  parameter int Dw        = 8,
  parameter int NumStages = 1,
  parameter int TagW      = 1
) (
  input logic            clk,
  input logic            rst_n,
  input logic            out_valid,
  input logic            out_ready,
  input logic [Dw-1:0]   data,
  input logic [TagW-1:0] tag
);
  localparam int Sw = $clog2(Dw);

  a_params: assert property (@(posedge clk)
    (((Dw & (Dw - 1)) == 0) && (NumStages >= 1) && (NumStages <= Sw)));

  a_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid && !out_ready) |=> ($stable(data) && $stable(tag)));

  a_keep_valid: assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid && !out_ready) |=> out_valid);
endmodule

// File: tb/tb_shifter_pipe.sv
// Scoreboard bench for shifter_pipe (Dw=8, NumStages=3, TagW=4).
module tb_shifter_pipe;
  localparam int DW = 8;
  localparam int NS = 3;
  localparam int TW = 4;

  logic       clk = 1'b0;
  logic       rst_ni = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] data_in = 8'h00;
  logic [3:0] shamt = 4'd0;
  logic [2:0] mode = 3'b000;
  logic [3:0] tag_in = 4'h0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] data_out;
  logic       sticky_out;
  logic [3:0] tag_out;

  shifter_pipe #(.Dw(DW), .NumStages(NS), .TagW(TW)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .data_i       (data_in),
    .shamt_i      (shamt),
    .shift_mode_i (mode),
    .tag_i        (tag_in),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .data_o       (data_out),
    .sticky_o     (sticky_out),
    .tag_o        (tag_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] d;
    logic       s;
    logic [3:0] t;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   n_acc = 0;
  int   n_del = 0;
  int   cyc = 0;
  int   last_del_cyc = 0;
  bit   dir_mode = 1'b0;
  exp_t dir_exp;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference shifter: right rotate computed directly, sticky from the input operand.
  function automatic exp_t ref_model(input logic [7:0] d, input logic [3:0] sh,
                                     input logic [2:0] m, input logic [3:0] t);
    exp_t        e;
    logic [15:0] dd;
    int          shv;
    int          r;
    shv = int'(sh);
    r   = shv % 8;
    dd  = {d, d};
    e.t = t;
    e.d = d;
    e.s = 1'b0;
    case (m)
      3'b000: begin
        if (shv >= 8) begin e.d = 8'h00; e.s = |d; end
        else begin e.d = d << shv; e.s = |(d >> (8 - shv)); end
      end
      3'b100: begin
        if (shv >= 8) begin e.d = 8'h00; e.s = |d; end
        else begin e.d = d >> shv; e.s = |(d & ((8'd1 << shv) - 8'd1)); end
      end
      3'b101: begin
        if (shv >= 8) begin e.d = {8{d[7]}}; e.s = |d; end
        else begin e.d = 8'($signed(d) >>> shv); e.s = |(d & ((8'd1 << shv) - 8'd1)); end
      end
      3'b011: begin dd = dd << r; e.d = dd[15:8]; end
      3'b111: begin dd = dd >> r; e.d = dd[7:0]; end
      default: begin e.d = d; end
    endcase
    return e;
  endfunction

  // One clock: sample mid-cycle, score the output, record acceptance, advance.
  task automatic step(output bit acc, output bit del);
    exp_t e;
    #4;
    acc = in_valid && in_ready && rst_ni;
    del = out_valid && out_ready && rst_ni;
    if (out_valid) begin
      check("out_has_expected", (sb.size() > 0) ? 32'd1 : 32'd0, 32'd1);
      if (sb.size() > 0) begin
        e = sb[0];
        check("data_o", data_out, e.d);
        check("sticky_o", sticky_out, e.s);
        check("tag_o", tag_out, e.t);
        if (del) begin
          void'(sb.pop_front());
          n_del++;
          last_del_cyc = cyc;
        end
      end
    end
    if (acc) begin
      n_acc++;
      sb.push_back(dir_mode ? dir_exp : ref_model(data_in, shamt, mode, tag_in));
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic send_op(input logic [7:0] d, input logic [3:0] sh, input logic [2:0] m,
                         input logic [3:0] t, input logic [7:0] ed, input logic es);
    bit acc, del, got;
    int lat;
    dir_mode  = 1'b1;
    dir_exp   = {ed, es, t};
    in_valid  = 1'b1;
    data_in   = d;
    shamt     = sh;
    mode      = m;
    tag_in    = t;
    out_ready = 1'b1;
    step(acc, del);
    check("accept_empty_pipe", acc, 1);
    in_valid = 1'b0;
    dir_mode = 1'b0;
    got = 1'b0;
    lat = 0;
    for (int k = 0; k < 10 && !got; k++) begin
      step(acc, del);
      lat++;
      if (del) got = 1'b1;
    end
    check("delivered", got, 1);
    check("latency", lat, NS);
  endtask

  initial begin
    bit         acc, del;
    int         k, first_c, c0, d0, a0;
    logic [2:0] modes [5];
    modes = '{3'b000, 3'b100, 3'b101, 3'b011, 3'b111};

    // Reset
    rst_ni = 1'b0;
    step(acc, del);
    step(acc, del);
    check("rst_out_valid", out_valid, 0);
    check("rst_data_o", data_out, 8'h00);
    check("rst_sticky_o", sticky_out, 0);
    check("rst_tag_o", tag_out, 4'h0);
    check("rst_in_ready", in_ready, 1);
    rst_ni = 1'b1;

    // Directed values
    send_op(8'hB5, 4'd3,  3'b000, 4'h5, 8'hA8, 1'b1);
    send_op(8'hB5, 4'd1,  3'b100, 4'h1, 8'h5A, 1'b1);
    send_op(8'h96, 4'd2,  3'b101, 4'h2, 8'hE5, 1'b1);
    send_op(8'h96, 4'd9,  3'b101, 4'h3, 8'hFF, 1'b1);
    send_op(8'h96, 4'd9,  3'b100, 4'h4, 8'h00, 1'b1);
    send_op(8'h81, 4'd1,  3'b111, 4'h6, 8'hC0, 1'b0);
    send_op(8'h81, 4'd12, 3'b011, 4'h7, 8'h18, 1'b0);
    for (int m = 0; m < 5; m++) send_op(8'hA7, 4'd0, modes[m], 4'(8 + m), 8'hA7, 1'b0);
    send_op(8'h01, 4'd7,  3'b000, 4'hD, 8'h80, 1'b0);
    send_op(8'h80, 4'd7,  3'b100, 4'hE, 8'h01, 1'b0);
    send_op(8'h80, 4'd7,  3'b101, 4'hF, 8'hFF, 1'b0);
    send_op(8'h96, 4'd7,  3'b101, 4'h1, 8'hFF, 1'b1);
    send_op(8'h80, 4'd8,  3'b000, 4'h2, 8'h00, 1'b1);
    send_op(8'h7F, 4'd15, 3'b101, 4'h3, 8'h00, 1'b1);
    send_op(8'h00, 4'd12, 3'b100, 4'h4, 8'h00, 1'b0);
    send_op(8'h81, 4'd9,  3'b111, 4'h5, 8'hC0, 1'b0);
    send_op(8'hA5, 4'd8,  3'b011, 4'h6, 8'hA5, 1'b0);
    send_op(8'h3C, 4'd5,  3'b010, 4'h9, 8'h3C, 1'b0);

    // Back-to-back with a 6-cycle output stall
    out_ready = 1'b0;
    k = 0;
    for (int c = 0; c < 6; c++) begin
      in_valid = (k < 5);
      data_in  = 8'h30 + 8'(k * 17);
      shamt    = 4'(k + 1);
      mode     = modes[k % 5];
      tag_in   = 4'(k);
      step(acc, del);
      if (acc) k++;
    end
    check("stall_accepts", k, 3);
    check("stall_in_ready", in_ready, 0);
    check("stall_out_valid", out_valid, 1);
    out_ready = 1'b1;
    d0 = n_del;
    c0 = cyc;
    first_c = -1;
    for (int c = 0; c < 20 && (n_del - d0) < 5; c++) begin
      in_valid = (k < 5);
      data_in  = 8'h30 + 8'(k * 17);
      shamt    = 4'(k + 1);
      mode     = modes[k % 5];
      tag_in   = 4'(k);
      step(acc, del);
      if (acc) k++;
      if (del && first_c < 0) first_c = last_del_cyc;
    end
    in_valid = 1'b0;
    check("release_count", n_del - d0, 5);
    check("release_first", first_c, c0);
    check("release_rate", last_del_cyc - first_c, 4);

    // Reset with two operations in flight
    out_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      in_valid = 1'b1;
      data_in  = 8'hC3;
      shamt    = 4'(c + 2);
      mode     = 3'b000;
      tag_in   = 4'hA;
      step(acc, del);
    end
    in_valid = 1'b0;
    rst_ni = 1'b0;
    step(acc, del);
    sb.delete();
    rst_ni = 1'b1;
    check("flush_out_valid", out_valid, 0);
    check("flush_data_o", data_out, 8'h00);
    d0 = n_del;
    for (int c = 0; c < 6; c++) step(acc, del);
    check("flush_no_ghost", n_del - d0, 0);

    // Random valid/ready traffic against the reference model
    a0 = n_acc;
    d0 = n_del;
    for (int c = 0; c < 20000 && (n_acc - a0) < 1500; c++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      data_in   = 8'($urandom);
      shamt     = 4'($urandom_range(0, 15));
      mode      = 3'($urandom_range(0, 7));
      tag_in    = 4'(n_acc);
      step(acc, del);
    end
    check("rand_accept_count", n_acc - a0, 1500);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 20 && sb.size() > 0; c++) step(acc, del);
    check("rand_drained", sb.size(), 0);
    check("rand_no_loss_dup", n_del - d0, n_acc - a0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
